// File: rtl/i2c_reg_target.sv
// I2C target exposing an NREGS x 8-bit register file, with a host-side access port.
// Define I2C_TARGET_GLITCH_FILT_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_reg_target #(
   parameter logic [6:0] ADDR  = 7'h34,
   parameter int         NREGS = 8,
   parameter int         PW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   input  logic          host_we,
   input  logic [PW-1:0] host_addr,
   input  logic [7:0]    host_wdata,
   output logic [7:0]    host_rdata,
   output logic          wr_valid,
   output logic [PW-1:0] wr_addr,
   output logic          busy,
   output logic [2:0]    dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ACK_ADDR, S_RX_PTR, S_RX_DATA, S_TX, S_RX_ACK
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    scl_sync_q, sda_sync_q;
   logic          scl_s, sda_s, scl_prev_q, sda_prev_q;
   logic          scl_rise, scl_fall, start_det, stop_det;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          sda_oe_q, sda_oe_d;
   logic          busy_q, busy_d;
   logic          wr_valid_q, wr_valid_d;
   logic [PW-1:0] wr_addr_q, wr_addr_d;
   logic          i2c_we;
   logic [7:0]    rx_byte, tx_byte;
   logic [7:0]    host_rdata_q;
   logic [7:0]    regs_q [NREGS];

   // Synchronizers reset to the idle-bus level so release of reset never looks like a START.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILT_EN
   logic [1:0] scl_hist_q, sda_hist_q;
   logic       scl_flt_q, sda_flt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_hist_q <= 2'b11;
         sda_hist_q <= 2'b11;
         scl_flt_q  <= 1'b1;
         sda_flt_q  <= 1'b1;
      end else begin
         scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
         sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
         scl_flt_q  <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                       (scl_hist_q[0] & scl_hist_q[1]);
         sda_flt_q  <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                       (sda_hist_q[0] & sda_hist_q[1]);
      end
   end

   assign scl_s = scl_flt_q;
   assign sda_s = sda_flt_q;
`else
   assign scl_s = scl_sync_q[1];
   assign sda_s = sda_sync_q[1];
`endif

   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign rx_byte   = {shreg_q[6:0], sda_s};
   assign tx_byte   = regs_q[ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         scl_prev_q   <= 1'b1;
         sda_prev_q   <= 1'b1;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         ptr_q        <= '0;
         sda_oe_q     <= 1'b0;
         busy_q       <= 1'b0;
         wr_valid_q   <= 1'b0;
         wr_addr_q    <= '0;
      end else begin
         state_q      <= state_d;
         scl_prev_q   <= scl_s;
         sda_prev_q   <= sda_s;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         ptr_q        <= ptr_d;
         sda_oe_q     <= sda_oe_d;
         busy_q       <= busy_d;
         wr_valid_q   <= wr_valid_d;
         wr_addr_q    <= wr_addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (stop_det) begin
         state_d = S_IDLE;
      end else if (start_det) begin
         state_d = S_ADDR;
      end else begin
         case (state_q)
            S_ADDR:     if (scl_rise && bit_cnt_q == 4'd7)
                           state_d = (shreg_q[6:0] == ADDR) ? S_ACK_ADDR : S_IDLE;
            S_ACK_ADDR: if (scl_fall && bit_cnt_q == 4'd9)
                           state_d = shreg_q[0] ? S_TX : S_RX_PTR;
            S_RX_PTR:   if (scl_fall && bit_cnt_q == 4'd9) state_d = S_RX_DATA;
            S_TX:       if (scl_fall && bit_cnt_q == 4'd8) state_d = S_RX_ACK;
            S_RX_ACK:   if (scl_rise && sda_s) state_d = S_IDLE;
                        else if (scl_fall && bit_cnt_q == 4'd9) state_d = S_TX;
            default:    state_d = state_q;
         endcase
      end
   end

   // bit_cnt counts SCL rises within a 9-bit frame: 8 means the ACK slot comes next, 9 means it was clocked.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      ptr_d      = ptr_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      i2c_we     = 1'b0;
      if (stop_det) begin
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_det) begin
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
         case (state_q)
            S_ADDR: begin
               if (scl_rise && bit_cnt_q < 4'd8) shreg_d = rx_byte;
            end
            S_ACK_ADDR: begin
               if (scl_fall && bit_cnt_q == 4'd8) begin
                  sda_oe_d = 1'b1;
                  busy_d   = 1'b1;
               end else if (scl_fall && bit_cnt_q == 4'd9) begin
                  bit_cnt_d = '0;
                  if (shreg_q[0]) begin
                     shreg_d  = {tx_byte[6:0], 1'b0};
                     sda_oe_d = ~tx_byte[7];
                  end else begin
                     sda_oe_d = 1'b0;
                  end
               end
            end
            S_RX_PTR, S_RX_DATA: begin
               if (scl_rise && bit_cnt_q < 4'd8) shreg_d = rx_byte;
               if (scl_rise && bit_cnt_q == 4'd7) begin
                  if (state_q == S_RX_PTR) begin
                     ptr_d = rx_byte[PW-1:0];
                  end else begin
                     i2c_we     = 1'b1;
                     wr_valid_d = 1'b1;
                     wr_addr_d  = ptr_q;
                     ptr_d      = ptr_q + 1'b1;
                  end
               end
               if (scl_fall && bit_cnt_q == 4'd8) begin
                  sda_oe_d = 1'b1;
               end else if (scl_fall && bit_cnt_q == 4'd9) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
               end
            end
            S_TX: begin
               if (scl_fall && bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd7) begin
                  sda_oe_d = ~shreg_q[7];
                  shreg_d  = {shreg_q[6:0], 1'b0};
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  sda_oe_d = 1'b0;
                  ptr_d    = ptr_q + 1'b1;
               end
            end
            S_RX_ACK: begin
               if (scl_fall && bit_cnt_q == 4'd9) begin
                  shreg_d   = {tx_byte[6:0], 1'b0};
                  sda_oe_d  = ~tx_byte[7];
                  bit_cnt_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   // I2C commit takes priority over a host write to the same register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (i2c_we && ptr_q == PW'(i)) regs_q[i] <= rx_byte;
            else if (host_we && host_addr == PW'(i)) regs_q[i] <= host_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) host_rdata_q <= '0;
      else        host_rdata_q <= regs_q[host_addr];
   end

   assign sda_oe      = sda_oe_q;
   assign host_rdata  = host_rdata_q;
   assign wr_valid    = wr_valid_q;
   assign wr_addr     = wr_addr_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule
